// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared 64-bit memory port between instruction fetch and load/store.
// Fixed-latency reads are returned to the owning requester; stores take a single write cycle.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 3;
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              owner_q;
  logic              last_q;
  logic              half_q;
  logic [CNT_W-1:0]  cnt_q;

  logic idle;
  logic grant_d;
  logic grant_if;
  logic rd_done;
  logic unused;

  // Grants only from IDLE; on contention the requester that did not win last time goes first.
  // Gated by rst so the grant outputs are also low during reset.
  assign idle     = (state == IDLE);
  assign grant_d  = rst & idle & d_req  & (~if_req | (last_q == OWN_FETCH));
  assign grant_if = rst & idle & if_req & (~d_req  | (last_q == OWN_DATA));
  assign rd_done  = (state == RD_WAIT) && (cnt_q == CNT_W'(MEM_LAT));

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign if_rvalid = rd_done & (owner_q == OWN_FETCH);
  assign d_rvalid  = rd_done & (owner_q == OWN_DATA);
  assign if_rdata  = if_rvalid ? (half_q ? mem_rdata[63:32] : mem_rdata[31:0]) : 32'd0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = (state == WR);
  assign busy      = ~idle;

  // Word alignment of fetches makes the low fetch address bits irrelevant.
  assign unused = ^if_addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= OWN_FETCH;
      last_q  <= OWN_FETCH;
      half_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner_q <= OWN_DATA;
            last_q  <= OWN_DATA;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            half_q  <= 1'b0;
            cnt_q   <= '0;
            state   <= d_we ? WR : RD_WAIT;
          end else if (grant_if) begin
            owner_q <= OWN_FETCH;
            last_q  <= OWN_FETCH;
            addr_q  <= {if_addr[ADDR_W-1:3], 3'b000};
            half_q  <= if_addr[2];
            cnt_q   <= '0;
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_done) state <= IDLE;
          else         cnt_q <= cnt_q + CNT_W'(1);
        end
        WR:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, load, store, contention, reset abort, MEM_LAT=3 load.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0] mem [0:63];

  // Instance with MEM_LAT=1
  logic        if_req, d_req, d_we;
  logic [63:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_wr, busy;
  logic [31:0] if_rdata;
  logic [63:0] d_rdata, mem_addr, mem_wdata, mem_rdata;

  // Instance with MEM_LAT=3
  logic        if_req3, d_req3, d_we3;
  logic [63:0] if_addr3, d_addr3, d_wdata3;
  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_wr3, busy3;
  logic [31:0] if_rdata3;
  logic [63:0] d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  assign mem_rdata  = mem[mem_addr[8:3]];
  assign mem_rdata3 = mem[mem_addr3[8:3]];

  always @(posedge clk) if (mem_wr) mem[mem_addr[8:3]] <= mem_wdata;

  mem_port_arbiter #(.MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_wr(mem_wr3), .mem_rdata(mem_rdata3),
    .busy(busy3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle; inputs are driven and outputs sampled 1-2 time units after posedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic fetch(input logic [63:0] a, input logic [31:0] exp_data, input string tag);
    if_req = 1'b1; if_addr = a;
    #1;
    chk({tag, "_gnt"}, 64'(if_gnt), 64'd1);
    chk({tag, "_busy0"}, 64'(busy), 64'd0);
    next_cycle();
    if_req = 1'b0;
    #1;
    chk({tag, "_gnt1"}, 64'(if_gnt), 64'd0);
    chk({tag, "_addr"}, mem_addr, 64'h8);
    chk({tag, "_rv1"}, 64'(if_rvalid), 64'd0);
    next_cycle();
    #1;
    chk({tag, "_rv2"}, 64'(if_rvalid), 64'd1);
    chk({tag, "_data"}, 64'(if_rdata), 64'(exp_data));
    next_cycle();
    #1;
    chk({tag, "_rv3"}, 64'(if_rvalid), 64'd0);
    chk({tag, "_rd3"}, 64'(if_rdata), 64'd0);
    chk({tag, "_idle3"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    if_req3 = 0; if_addr3 = 0; d_req3 = 0; d_we3 = 0; d_addr3 = 0; d_wdata3 = 0;
    for (int i = 0; i < 64; i++) mem[i] = 64'(i) * 64'h0101_0101;
    mem[1]  = 64'hAAAA_BBBB_1111_2222;
    mem[32] = 64'h0123_4567_89AB_CDEF;
    mem[4]  = 64'h0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wr", 64'(mem_wr), 64'd0);
    do_reset();

    // Fetch lower and upper halves of the word at 0x8
    fetch(64'h8, 32'h1111_2222, "f8");
    fetch(64'hC, 32'hAAAA_BBBB, "fC");

    // Load
    d_req = 1; d_we = 0; d_addr = 64'h100;
    #1;
    chk("ld_gnt", 64'(d_gnt), 64'd1);
    next_cycle();
    d_req = 0;
    #1;
    chk("ld_busy1", 64'(busy), 64'd1);
    chk("ld_rv1", 64'(d_rvalid), 64'd0);
    next_cycle();
    #1;
    chk("ld_busy2", 64'(busy), 64'd1);
    chk("ld_rv2", 64'(d_rvalid), 64'd1);
    chk("ld_data", d_rdata, 64'h0123_4567_89AB_CDEF);
    chk("ld_ifrv", 64'(if_rvalid), 64'd0);
    next_cycle();
    #1;
    chk("ld_busy3", 64'(busy), 64'd0);
    chk("ld_rd3", d_rdata, 64'd0);

    // Store
    d_req = 1; d_we = 1; d_addr = 64'h20; d_wdata = 64'hDEAD_BEEF;
    #1;
    chk("st_gnt", 64'(d_gnt), 64'd1);
    chk("st_wr0", 64'(mem_wr), 64'd0);
    next_cycle();
    d_req = 0; d_we = 0;
    #1;
    chk("st_wr1", 64'(mem_wr), 64'd1);
    chk("st_addr", mem_addr, 64'h20);
    chk("st_wdata", mem_wdata, 64'hDEAD_BEEF);
    chk("st_rv1", 64'(d_rvalid), 64'd0);
    next_cycle();
    #1;
    chk("st_wr2", 64'(mem_wr), 64'd0);
    chk("st_busy2", 64'(busy), 64'd0);
    chk("st_rv2", 64'(d_rvalid), 64'd0);
    chk("st_mem", mem[4], 64'hDEAD_BEEF);

    // Contention from reset: D, IF, D, IF, one grant every 3 cycles
    if_req = 1; if_addr = 64'h8; d_req = 1; d_we = 0; d_addr = 64'h100;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("ct%0d_dgnt", k), 64'(d_gnt), 64'((k % 2) == 0));
      chk($sformatf("ct%0d_ifgnt", k), 64'(if_gnt), 64'((k % 2) == 1));
      next_cycle();
      #1;
      chk($sformatf("ct%0d_nogntA", k), 64'(d_gnt | if_gnt), 64'd0);
      next_cycle();
      #1;
      chk($sformatf("ct%0d_nogntB", k), 64'(d_gnt | if_gnt), 64'd0);
      chk($sformatf("ct%0d_drv", k), 64'(d_rvalid), 64'((k % 2) == 0));
      chk($sformatf("ct%0d_ifrv", k), 64'(if_rvalid), 64'((k % 2) == 1));
      next_cycle();
    end
    if_req = 0; d_req = 0;

    // Reset in the middle of a load
    do_reset();
    d_req = 1; d_we = 0; d_addr = 64'h100;
    #1;
    chk("ab_gnt", 64'(d_gnt), 64'd1);
    next_cycle();
    rst = 1'b0;
    #1;
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_dgnt", 64'(d_gnt), 64'd0);
    chk("ab_addr", mem_addr, 64'd0);
    chk("ab_rv", 64'(d_rvalid), 64'd0);
    next_cycle();
    chk("ab_rv2", 64'(d_rvalid), 64'd0);
    d_req = 0; if_req = 1; if_addr = 64'hC;
    rst = 1'b1;
    #1;
    chk("ab_ifgnt", 64'(if_gnt), 64'd1);
    next_cycle();
    if_req = 0;
    #1;
    chk("ab_drv_after", 64'(d_rvalid), 64'd0);
    next_cycle();
    #1;
    chk("ab_ifrv", 64'(if_rvalid), 64'd1);
    chk("ab_ifdata", 64'(if_rdata), 64'hAAAA_BBBB);
    next_cycle();

    // MEM_LAT=3 load on the second instance
    d_req3 = 1; d_we3 = 0; d_addr3 = 64'h100;
    #1;
    chk("l3_gnt", 64'(d_gnt3), 64'd1);
    next_cycle();
    d_req3 = 0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("l3_busy%0d", c), 64'(busy3), 64'(c <= 4));
      chk($sformatf("l3_rv%0d", c), 64'(d_rvalid3), 64'(c == 4));
      if (c == 4) chk("l3_data", d_rdata3, 64'h0123_4567_89AB_CDEF);
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
